// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : aes_pkg
//  Description : Shared AES definitions: block/word/byte types, the inverse
//                S-box, GF(2^8) multiply helpers and the decryption FSM
//                state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef logic [7:0]             byte_t;
    typedef logic [31:0]            word_t;
    // Big-endian block: byte 0 occupies bits [127:120], bytes are column-major
    typedef logic [AES_BLOCK_W-1:0] block_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam byte_t c_inv_sbox [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Multiply by {02} modulo x^8+x^4+x^3+x+1
    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul09(input byte_t b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic byte_t gf_mul0b(input byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic byte_t gf_mul0d(input byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic byte_t gf_mul0e(input byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // InvMixColumns on one column; row 0 sits in the most significant byte
    function automatic word_t inv_mix_column(input word_t col);
        byte_t a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gf_mul0e(a0) ^ gf_mul0b(a1) ^ gf_mul0d(a2) ^ gf_mul09(a3),
                gf_mul09(a0) ^ gf_mul0e(a1) ^ gf_mul0b(a2) ^ gf_mul0d(a3),
                gf_mul0d(a0) ^ gf_mul09(a1) ^ gf_mul0e(a2) ^ gf_mul0b(a3),
                gf_mul0b(a0) ^ gf_mul0d(a1) ^ gf_mul09(a2) ^ gf_mul0e(a3)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_round.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_round
//  Description : Combinational AES inverse round:
//                InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
//                InvMixColumns is bypassed when 'last' is set.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_inv_round
    import aes_pkg::*;
(
    input  block_t state,
    input  block_t rk,
    input  logic   last,
    output block_t next
);

    byte_t w_sub [16];
    byte_t w_ark [16];

    for (genvar gc = 0; gc < 4; gc++) begin : g_col
        word_t w_ark_col;
        word_t w_mix_col;

        for (genvar gr = 0; gr < 4; gr++) begin : g_row
            // InvShiftRows: row r rotates right by r, so dest col c reads col c-r
            localparam int c_dst = gr + 4 * gc;
            localparam int c_src = gr + 4 * ((gc - gr + 4) % 4);

            assign w_sub[c_dst] = c_inv_sbox[state[AES_BLOCK_W-1-8*c_src -: 8]];
            assign w_ark[c_dst] = w_sub[c_dst] ^ rk[AES_BLOCK_W-1-8*c_dst -: 8];
        end

        assign w_ark_col = {w_ark[4*gc], w_ark[4*gc+1], w_ark[4*gc+2], w_ark[4*gc+3]};
        assign w_mix_col = inv_mix_column(w_ark_col);
        assign next[AES_BLOCK_W-1-32*gc -: 32] = last ? w_ark_col : w_mix_col;
    end

endmodule
`default_nettype wire

// File: rtl/aes_inv_cipher_iter.sv
`default_nettype none
// ============================================================================
//  Module      : aes_inv_cipher_iter
//  Description : Iterative AES decryption core. One inverse round per clock
//                through a shared aes_inv_round instance; round keys are
//                fetched from an external expanded-key store via rk_idx.
//                Optional macro ROUND_TRACE_EN enables simulation-only
//                round tracing with no functional change.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] ct,
    output logic [3:0]             rk_idx,
    input  logic [AES_BLOCK_W-1:0] rk,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] pt
);

    // Round count must match the key length (AES-128/192/256)
    if (Nr != Nk + 6) begin : g_cfg_check
        $error("aes_inv_cipher_iter: Nr must equal Nk+6");
    end

    localparam logic [3:0] c_nr_idx   = 4'(Nr);
    localparam logic [3:0] c_nr_m1    = 4'(Nr - 1);

    state_t     r_fsm;
    state_t     w_fsm_nxt;
    block_t     r_state;
    block_t     w_state_nxt;
    logic [3:0] r_rnd;
    logic [3:0] w_rnd_nxt;
    block_t     w_round_out;
    logic       w_last;

    assign w_last = (r_fsm == ST_FINAL);

    aes_inv_round u_round (
        .state (r_state),
        .rk    (rk),
        .last  (w_last),
        .next  (w_round_out)
    );

    // State, round counter and FSM registers; reset aborts any block in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm   <= ST_IDLE;
            r_state <= '0;
            r_rnd   <= '0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_state <= w_state_nxt;
            r_rnd   <= w_rnd_nxt;
        end
    end

    // Next-state, datapath select and output decode from FSM state and rnd
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_rnd_nxt   = r_rnd;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        pt          = '0;
        rk_idx      = c_nr_idx;

        case (r_fsm)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ct ^ rk;
                    w_rnd_nxt   = c_nr_m1;
                    w_fsm_nxt   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                rk_idx      = r_rnd;
                w_state_nxt = w_round_out;
                if (r_rnd == 4'd1) begin
                    w_rnd_nxt = 4'd0;
                    w_fsm_nxt = ST_FINAL;
                end else begin
                    w_rnd_nxt = r_rnd - 4'd1;
                end
            end
            ST_FINAL: begin
                rk_idx      = 4'd0;
                w_state_nxt = w_round_out;
                w_fsm_nxt   = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                pt        = r_state;
                if (out_ready) begin
                    w_fsm_nxt = ST_IDLE;
                end
            end
            default: begin
                w_fsm_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef ROUND_TRACE_EN
    // Simulation-only trace of accepts, rounds and completions
    always @(posedge clk) begin
        if (!rst) begin
            if (r_fsm == ST_IDLE && in_valid)
                $display("[aes_inv] accept ct=%h", ct);
            if (r_fsm == ST_ROUND || r_fsm == ST_FINAL)
                $display("[aes_inv] rnd=%0d rk_idx=%0d before=%h after=%h",
                         r_rnd, rk_idx, r_state, w_state_nxt);
            if (r_fsm == ST_DONE && out_ready)
                $display("[aes_inv] complete pt=%h", r_state);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_cipher_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_inv_cipher_iter
//  Description : Scoreboard bench for aes_inv_cipher_iter (AES-128 and AES-256
//                instances). Expected plaintexts come from FIPS-197 vectors or
//                from a forward-cipher reference model applied to random data.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_inv_cipher_iter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid_v  [2];
    logic         in_ready_v  [2];
    logic         out_valid_v [2];
    logic         out_ready_v [2];
    logic [127:0] ct_v  [2];
    logic [127:0] pt_v  [2];
    logic [127:0] rk_v  [2];
    logic [3:0]   rk_idx_v [2];
    logic [127:0] ks [2][16];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = 0;

    logic [7:0] sbox [256];

    typedef struct {
        int           dut;
        logic [127:0] pt;
        int           acc;
    } exp_t;
    exp_t sbq [$];

    localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    assign rk_v[0] = ks[0][rk_idx_v[0]];
    assign rk_v[1] = ks[1][rk_idx_v[1]];

    aes_inv_cipher_iter #(.Nk(4), .Nr(10)) u_dut10 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .ct(ct_v[0]),
        .rk_idx(rk_idx_v[0]), .rk(rk_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .pt(pt_v[0])
    );

    aes_inv_cipher_iter #(.Nk(8), .Nr(14)) u_dut14 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .ct(ct_v[1]),
        .rk_idx(rk_idx_v[1]), .rk(rk_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .pt(pt_v[1])
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- reference model: forward AES from first principles ----
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box = affine transform of the multiplicative inverse in GF(2^8)
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0]  inv = 8'h00;
            logic [7:0]  s;
            logic [15:0] t;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            t = {inv, inv};
            s = inv ^ t[14:7] ^ t[13:6] ^ t[12:5] ^ t[11:4] ^ 8'h63;
            sbox[x] = s;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk, output logic [127:0] k [16]);
        logic [31:0] w [64];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        int nw = 4 * (nk + 7);
        for (int i = 0; i < 64; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            k[r] = (r <= nk + 6) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    task automatic encrypt(input logic [127:0] p, input logic [255:0] key, input int nk,
                           output logic [127:0] c);
        logic [127:0] k [16];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        int nr = nk + 6;
        expand(key, nk, k);
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ k[0][127-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int c2 = 0; c2 < 4; c2++)
                for (int rr = 0; rr < 4; rr++)
                    t[rr+4*c2] = s[rr + 4*((c2 + rr) % 4)];
            for (int c2 = 0; c2 < 4; c2++) begin
                logic [7:0] a0 = t[4*c2], a1 = t[4*c2+1], a2 = t[4*c2+2], a3 = t[4*c2+3];
                if (r < nr) begin
                    s[4*c2]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c2+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c2+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c2+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4*c2] = a0; s[4*c2+1] = a1; s[4*c2+2] = a2; s[4*c2+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) c[127-8*i -: 8] = s[i];
    endtask

    // ---------------- checking helpers --------------------------------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endtask

    // Offer one block to DUT d once it is idle; expected result goes to the scoreboard
    task automatic issue(input int d, input logic [127:0] c, input logic [127:0] exp_pt,
                         input logic [255:0] key, input int nk);
        logic [127:0] k [16];
        exp_t e;
        int n = 0;
        while (!in_ready_v[d] && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready_v[d]) begin
            fail_now("accept_timeout");
            return;
        end
        expand(key, nk, k);
        for (int i = 0; i < 16; i++) ks[d][i] = k[i];
        ct_v[d]     = c;
        in_valid_v[d] = 1'b1;
        e.dut = d; e.pt = exp_pt; e.acc = cyc + 1;
        sbq.push_back(e);
        last_acc = cyc + 1;
        @(posedge clk); #1;
        in_valid_v[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        while ((sbq.size() != 0 || !in_ready_v[d]) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) fail_now("completion_timeout");
    endtask

    // ---------------- monitor: latency on out_valid rise, data on handshake -
    initial begin
        logic prev [2];
        exp_t e;
        prev[0] = 1'b0;
        prev[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    prev[d] = 1'b0;
                end else begin
                    if (out_valid_v[d] && !prev[d]) begin
                        if (sbq.size() == 0 || sbq[0].dut != d)
                            fail_now("unexpected_out_valid");
                        else
                            chk("latency", 128'(cyc - sbq[0].acc), (d == 0) ? 128'd10 : 128'd14);
                    end
                    if (out_valid_v[d] && out_ready_v[d]) begin
                        if (sbq.size() == 0 || sbq[0].dut != d) begin
                            fail_now("unexpected_handshake");
                        end else begin
                            e = sbq.pop_front();
                            chk("pt", pt_v[d], e.pt);
                        end
                    end
                    prev[d] = out_valid_v[d];
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------------------------------------
    initial begin
        logic [127:0] p, c, hold;
        logic [255:0] key;
        int a1, a2, n;

        for (int d = 0; d < 2; d++) begin
            in_valid_v[d] = 1'b0;
            out_ready_v[d] = 1'b1;
            ct_v[d] = '0;
            for (int i = 0; i < 16; i++) ks[d][i] = '0;
        end
        build_sbox();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  128'(in_ready_v[0]),  128'd1);
        chk("rst_out_valid", 128'(out_valid_v[0]), 128'd0);
        chk("rst_pt",        pt_v[0],              128'd0);
        chk("rst_rk_idx10",  128'(rk_idx_v[0]),    128'd10);
        chk("rst_rk_idx14",  128'(rk_idx_v[1]),    128'd14);
        rst = 1'b0;
        @(posedge clk); #1;

        // FIPS-197 App.B
        issue(0, CT_B, PT_B, KEY_B, 4);
        wait_done(0);

        // FIPS-197 C.1 with round-key index trail
        chk("idle_rk_idx", 128'(rk_idx_v[0]), 128'd10);
        issue(0, CT_C1, PT_C, KEY_C1, 4);
        for (int k = 9; k >= 0; k--) begin
            chk("rk_idx_seq", 128'(rk_idx_v[0]), 128'(k));
            @(posedge clk); #1;
        end
        chk("done_rk_idx", 128'(rk_idx_v[0]), 128'd10);
        wait_done(0);

        // FIPS-197 C.3 on the AES-256 instance
        issue(1, CT_C3, PT_C, KEY_C3, 8);
        wait_done(1);

        // Backpressure in DONE, with an ignored in_valid
        out_ready_v[0] = 1'b0;
        issue(0, CT_C1, PT_C, KEY_C1, 4);
        n = 0;
        while (!out_valid_v[0] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid_v[0]) fail_now("stall_reach_done");
        hold = pt_v[0];
        for (int i = 0; i < 5; i++) begin
            in_valid_v[0] = 1'b1;
            ct_v[0] = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            chk("stall_out_valid", 128'(out_valid_v[0]), 128'd1);
            chk("stall_in_ready",  128'(in_ready_v[0]),  128'd0);
            chk("stall_pt_stable", pt_v[0],              PT_C);
        end
        in_valid_v[0] = 1'b0;
        out_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        chk("release_out_valid", 128'(out_valid_v[0]), 128'd0);
        chk("release_in_ready",  128'(in_ready_v[0]),  128'd1);
        issue(0, CT_B, PT_B, KEY_B, 4);
        wait_done(0);

        // Asynchronous reset in the middle of a block
        issue(0, CT_C1, PT_C, KEY_C1, 4);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 128'(out_valid_v[0]), 128'd0);
        chk("abort_in_ready",  128'(in_ready_v[0]),  128'd1);
        chk("abort_pt",        pt_v[0],              128'd0);
        chk("abort_rk_idx",    128'(rk_idx_v[0]),    128'd10);
        sbq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        issue(0, CT_C1, PT_C, KEY_C1, 4);
        wait_done(0);

        // Back-to-back blocks, accept spacing Nr+2
        issue(0, CT_C1, PT_C, KEY_C1, 4);
        a1 = last_acc;
        issue(0, CT_B, PT_B, KEY_B, 4);
        a2 = last_acc;
        chk("b2b_spacing1", 128'(a2 - a1), 128'd12);
        issue(0, CT_C1, PT_C, KEY_C1, 4);
        chk("b2b_spacing2", 128'(last_acc - a2), 128'd12);
        wait_done(0);

        // Random keys and plaintexts, AES-128
        for (int i = 0; i < 6; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
            p   = {$urandom, $urandom, $urandom, $urandom};
            encrypt(p, key, 4, c);
            issue(0, c, p, key, 4);
        end
        wait_done(0);

        // Random keys and plaintexts, AES-256
        for (int i = 0; i < 3; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            p   = {$urandom, $urandom, $urandom, $urandom};
            encrypt(p, key, 8, c);
            issue(1, c, p, key, 8);
        end
        wait_done(1);

        chk("scoreboard_empty", 128'(sbq.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
